// File: rtl/isram_pkg.sv
// Shared definitions for the instruction-SRAM arbiter.
//   arb_state_e     : FSM encoding (IDLE = fetch owns the port, DATA = last cycle was a data grant)
//   ISRAM_DW/MASKW  : SRAM data and byte-mask widths
//   MAX_DBURST_DEF  : default burst limit for back-to-back data grants
//   CNT_W           : burst counter width (covers limits up to 15)
package isram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } arb_state_e;

  localparam int ISRAM_DW       = 64;
  localparam int ISRAM_MASKW    = 8;
  localparam int MAX_DBURST_DEF = 4;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/isram_arb.sv
// isram_arb: shares the single-port instruction SRAM between the fetch unit
// and the data-side load/store path. Data has priority, but after
// MAX_DBURST consecutive data grants fetch is handed one cycle.
//
// Ports:
//   clk, cpurst            : clock, synchronous active-high reset
//   fe_cs, fe_adr          : fetch select and address [31:3]
//   fe_rvalid              : fetch read data valid on sram_rdata
//   d_req/we/adr/wdata/wmask, d_gnt : data request, accepted when d_gnt
//   d_rvalid, d_rdata      : data read return (1 cycle after grant)
//   lr_isram_cs            : data owns the SRAM this cycle (fetch holds pc)
//   lr_isram_cs_endp       : fetch regains the SRAM, re-issues its address
//   sram_*                 : SRAM macro port, read data has 1-cycle latency
module isram_arb
  import isram_pkg::*;
#(
  parameter int MAX_DBURST = MAX_DBURST_DEF,
  parameter int SRAM_AW    = 13
) (
  input  logic                   clk,
  input  logic                   cpurst,
  input  logic                   fe_cs,
  input  logic [28:0]            fe_adr,
  output logic                   fe_rvalid,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [28:0]            d_adr,
  input  logic [ISRAM_DW-1:0]    d_wdata,
  input  logic [ISRAM_MASKW-1:0] d_wmask,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [ISRAM_DW-1:0]    d_rdata,
  output logic                   lr_isram_cs,
  output logic                   lr_isram_cs_endp,
  output logic                   sram_cs,
  output logic                   sram_we,
  output logic [SRAM_AW-1:0]     sram_adr,
  output logic [ISRAM_DW-1:0]    sram_wdata,
  output logic [ISRAM_MASKW-1:0] sram_wmask,
  input  logic [ISRAM_DW-1:0]    sram_rdata
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_DBURST);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fe_rvalid_q, d_rvalid_q;

  // Address bits above the SRAM index simply alias.
  logic unused_adr;
  assign unused_adr = ^{fe_adr[28:SRAM_AW], d_adr[28:SRAM_AW]};

  // Grant / endp and next state
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    // In IDLE cnt is always 0, so the limit only bites inside a burst.
    d_gnt            = d_req & ~cpurst & ((state_q == IDLE) | (cnt_q < BURST_LIM));
    lr_isram_cs      = d_gnt;
    // Masked by reset so no endp pulse escapes while the arbiter is held.
    lr_isram_cs_endp = (state_q == DATA) & ~d_gnt & ~cpurst;
    if (d_gnt) begin
      state_d = DATA;
      cnt_d   = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // SRAM port mux; fetch drives it whenever data is not granted (incl. reset)
  always_comb begin
    if (d_gnt) begin
      sram_cs    = 1'b1;
      sram_we    = d_we;
      sram_adr   = d_adr[SRAM_AW-1:0];
      sram_wdata = d_wdata;
      sram_wmask = d_wmask;
    end else begin
      // endp forces a select so the held fetch address is re-read.
      sram_cs    = fe_cs | lr_isram_cs_endp;
      sram_we    = 1'b0;
      sram_adr   = fe_adr[SRAM_AW-1:0];
      sram_wdata = '0;
      sram_wmask = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fe_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fe_rvalid_q <= sram_cs & ~d_gnt;
      d_rvalid_q  <= d_gnt & ~d_we;
    end
  end

  assign fe_rvalid = fe_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = sram_rdata;

endmodule

// File: tb/tb_isram_arb.sv
module tb_isram_arb;

  logic        clk = 1'b0;
  logic        cpurst, fe_cs, d_req, d_we;
  logic [28:0] fe_adr, d_adr;
  logic [63:0] d_wdata, d_rdata, sram_wdata, sram_rdata;
  logic [7:0]  d_wmask, sram_wmask;
  logic        fe_rvalid, d_gnt, d_rvalid, lr_isram_cs, lr_isram_cs_endp, sram_cs, sram_we;
  logic [12:0] sram_adr;

  always #5 clk = ~clk;

  isram_arb #(.MAX_DBURST(4), .SRAM_AW(13)) dut (
    .clk(clk), .cpurst(cpurst), .fe_cs(fe_cs), .fe_adr(fe_adr), .fe_rvalid(fe_rvalid),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .lr_isram_cs(lr_isram_cs), .lr_isram_cs_endp(lr_isram_cs_endp),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  // SRAM macro model: 1-cycle read latency, byte-masked writes
  logic [63:0] mem [0:8191];

  function automatic logic [63:0] pat(int i);
    return {32'hC0DE_0000 ^ i, 32'h0BAD_0000 + i};
  endfunction

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_wmask[b]) mem[sram_adr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_adr];
      end
    end
  end

  typedef struct {
    logic        rst, fcs;
    logic [28:0] fadr;
    logic        dreq, dwe;
    logic [28:0] dadr;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic        gnt, endp, scs, swe;
    logic [12:0] sadr;
    logic        frv, drv;
    logic [63:0] rd;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t v(logic rst, logic fcs, logic [28:0] fadr, logic dreq, logic dwe,
                             logic [28:0] dadr, logic [63:0] wd, logic [7:0] wm,
                             logic gnt, logic endp, logic scs, logic swe, logic [12:0] sadr,
                             logic frv, logic drv, logic [63:0] rd);
    vec_t r;
    r.rst = rst; r.fcs = fcs; r.fadr = fadr; r.dreq = dreq; r.dwe = dwe; r.dadr = dadr;
    r.wd = wd; r.wm = wm; r.gnt = gnt; r.endp = endp; r.scs = scs; r.swe = swe;
    r.sadr = sadr; r.frv = frv; r.drv = drv; r.rd = rd;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    cpurst = r.rst; fe_cs = r.fcs; fe_adr = r.fadr; d_req = r.dreq; d_we = r.dwe;
    d_adr = r.dadr; d_wdata = r.wd; d_wmask = r.wm;
  endtask

  initial begin
    logic [63:0] p40, w40;
    localparam logic [63:0] WD = 64'hDEADBEEF_12345678;
    for (int i = 0; i < 8192; i++) mem[i] = pat(i);
    p40 = pat(32'h40);
    w40 = {p40[63:32], 32'h12345678};

    //      rst fcs fadr     dreq we dadr      wd  wm     gnt endp scs swe sadr    frv drv rd
    vecs.push_back(v(1, 0, 29'h100, 1, 0, 29'h40, 0, 0,     0, 0, 0, 0, 13'h100, 0, 0, 0));
    // fetch only
    vecs.push_back(v(0, 1, 29'h100, 0, 0, 29'h40, 0, 0,     0, 0, 1, 0, 13'h100, 0, 0, 0));
    vecs.push_back(v(0, 1, 29'h100, 0, 0, 29'h40, 0, 0,     0, 0, 1, 0, 13'h100, 1, 0, 0));
    // data read collides with fetch
    vecs.push_back(v(0, 1, 29'h100, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 1, 0, 0));
    vecs.push_back(v(0, 1, 29'h100, 0, 0, 29'h40, 0, 0,     0, 1, 1, 0, 13'h100, 0, 1, p40));
    // masked write
    vecs.push_back(v(0, 1, 29'h100, 1, 1, 29'h40, WD, 8'h0F, 1, 0, 1, 1, 13'h040, 1, 0, 0));
    vecs.push_back(v(0, 0, 29'h100, 0, 0, 29'h40, 0, 0,     0, 1, 1, 0, 13'h100, 0, 0, 0));
    vecs.push_back(v(0, 0, 29'h100, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 1, 0, 0));
    vecs.push_back(v(0, 0, 29'h100, 0, 0, 29'h40, 0, 0,     0, 1, 1, 0, 13'h100, 0, 1, w40));
    vecs.push_back(v(0, 0, 29'h100, 0, 0, 29'h40, 0, 0,     0, 0, 0, 0, 13'h100, 1, 0, 0));
    vecs.push_back(v(0, 0, 29'h100, 0, 0, 29'h40, 0, 0,     0, 0, 0, 0, 13'h100, 0, 0, 0));
    // 10-cycle data burst, limit 4: 1111 0 1111 0
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 0, 0));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     0, 1, 1, 0, 13'h200, 0, 1, w40));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 1, 0, 0));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 1, 29'h200, 1, 0, 29'h40, 0, 0,     0, 1, 1, 0, 13'h200, 0, 1, w40));
    vecs.push_back(v(0, 0, 29'h200, 0, 0, 29'h40, 0, 0,     0, 0, 0, 0, 13'h200, 1, 0, 0));
    // aliased data address, then reset on the 2nd burst cycle
    vecs.push_back(v(0, 0, 29'h200, 1, 0, 29'h2040, 0, 0,   1, 0, 1, 0, 13'h040, 0, 0, 0));
    vecs.push_back(v(1, 1, 29'h300, 1, 0, 29'h40, 0, 0,     0, 0, 1, 0, 13'h300, 0, 1, w40));
    vecs.push_back(v(0, 0, 29'h300, 0, 0, 29'h40, 0, 0,     0, 0, 0, 0, 13'h300, 0, 0, 0));
    // counter restarts from 0 after reset: four grants then the fairness slot
    vecs.push_back(v(0, 0, 29'h300, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 0, 0));
    vecs.push_back(v(0, 0, 29'h300, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 0, 29'h300, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 0, 29'h300, 1, 0, 29'h40, 0, 0,     1, 0, 1, 0, 13'h040, 0, 1, w40));
    vecs.push_back(v(0, 0, 29'h300, 1, 0, 29'h40, 0, 0,     0, 1, 1, 0, 13'h300, 0, 1, w40));
    vecs.push_back(v(0, 0, 29'h300, 0, 0, 29'h40, 0, 0,     0, 0, 0, 0, 13'h300, 1, 0, 0));

    cpurst = 1'b1; fe_cs = 1'b0; fe_adr = '0; d_req = 1'b0; d_we = 1'b0;
    d_adr = '0; d_wdata = '0; d_wmask = '0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      vec_t r;
      r = vecs[i];
      @(negedge clk);
      drive(r);
      #1;
      chk($sformatf("r%0d d_gnt", i),       d_gnt,            r.gnt);
      chk($sformatf("r%0d lr_cs", i),       lr_isram_cs,      r.gnt);
      chk($sformatf("r%0d endp", i),        lr_isram_cs_endp, r.endp);
      chk($sformatf("r%0d sram_cs", i),     sram_cs,          r.scs);
      chk($sformatf("r%0d sram_we", i),     sram_we,          r.swe);
      chk($sformatf("r%0d sram_adr", i),    sram_adr,         r.sadr);
      chk($sformatf("r%0d sram_wmask", i),  sram_wmask,       r.gnt ? r.wm : 8'h00);
      chk($sformatf("r%0d sram_wdata", i),  sram_wdata,       r.gnt ? r.wd : 64'h0);
      chk($sformatf("r%0d fe_rvalid", i),   fe_rvalid,        r.frv);
      chk($sformatf("r%0d d_rvalid", i),    d_rvalid,         r.drv);
      if (r.drv) chk($sformatf("r%0d d_rdata", i), d_rdata, r.rd);
    end

    // Long continuous data pressure alongside fetch: every 5th cycle goes to fetch.
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      cpurst = 1'b0; fe_cs = 1'b1; fe_adr = 29'h123; d_req = 1'b1; d_we = 1'b0; d_adr = 29'h41;
      #1;
      chk($sformatf("burst c%0d d_gnt", c), d_gnt,            (c % 5) != 4);
      chk($sformatf("burst c%0d endp", c),  lr_isram_cs_endp, (c % 5) == 4);
      chk($sformatf("burst c%0d fe_rv", c), fe_rvalid,        c > 0 && (c % 5) == 0);
      if ((c % 5) == 4) chk($sformatf("burst c%0d sram_adr", c), sram_adr, 13'h123);
    end

    @(negedge clk);
    d_req = 1'b0; fe_cs = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/isram_arb.md
Name: isram_arb

Overview:
- Arbitrates the single-port, 64-bit-wide instruction SRAM between two requesters: the fetch unit (genpc) and the data-side load/store path, which reads constants or writes code.
- Generates `lr_isram_cs` and `lr_isram_cs_endp`, which genpc consumes to hold the pc and then re-issue the interrupted fetch.
- Data requests have priority over fetch, bounded by a burst limit so fetch always makes progress.
- Sits between genpc/load-store unit and the isram macro.

Parameters:
- `MAX_DBURST`, 4, maximum consecutive data-grant cycles before fetch is given one cycle (legal range 1..15).
- `SRAM_AW`, 13, SRAM index width; `sram_adr` = `adr[SRAM_AW+2:3]`.

Ports:
- `clk` in 1: clock.
- `cpurst` in 1: reset, synchronous active-high.
- `fe_cs` in 1: fetch SRAM select (genpc `isram_cs`).
- `fe_adr` in 29: fetch address [31:3].
- `fe_rvalid` out 1: fetch read data valid on `sram_rdata`.
- `d_req` in 1: data access request; held until `d_gnt`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_adr` in 29: data address [31:3].
- `d_wdata` in 64: write data.
- `d_wmask` in 8: byte write enables.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: data read data valid.
- `d_rdata` out 64: data read data.
- `lr_isram_cs` out 1: data owns the SRAM this cycle; fetch must hold pc.
- `lr_isram_cs_endp` out 1: first cycle fetch regains the SRAM; fetch re-issues its address.
- `sram_cs` out 1: SRAM chip select.
- `sram_we` out 1: SRAM write enable.
- `sram_adr` out `SRAM_AW`: SRAM index.
- `sram_wdata` out 64: SRAM write data.
- `sram_wmask` out 8: SRAM byte mask.
- `sram_rdata` in 64: SRAM read data, 1-cycle latency.

Behaviour:
- Clock `clk`; reset `cpurst`, synchronous, active-high.
- Reset state: FSM = IDLE, `cnt` = 0, `fe_rvalid` = 0, `d_rvalid` = 0.
- During `cpurst`:
  - `d_gnt` = 0, `lr_isram_cs` = 0, `lr_isram_cs_endp` = 0.
  - SRAM port is driven from fetch, so the boot fetch proceeds.
- FSM states:
  - IDLE: fetch owns the port.
  - DATA: the previous cycle was a data grant.
- Grant equation (combinational): `d_gnt` = `d_req` & !`cpurst` & (state==IDLE | `cnt` < `MAX_DBURST`).
- `lr_isram_cs` = `d_gnt`, combinational, same cycle as the grant.
- `lr_isram_cs_endp` = (state==DATA) & !`d_gnt`.
- IDLE transitions:
  - `d_gnt` → DATA, `cnt` <= 1.
  - Otherwise stay IDLE.
- DATA transitions:
  - `d_gnt` → DATA, `cnt` <= `cnt` + 1.
  - Otherwise → IDLE, `cnt` <= 0. This is the endp cycle; fetch owns the port.
- Fairness: at `cnt` == `MAX_DBURST` the grant is forced low for one cycle even if `d_req` is high. In that cycle endp asserts and fetch gets the port. The next cycle is IDLE and may grant data again.
- SRAM mux:
  - When `d_gnt`: `sram_cs`=1, `sram_we`=`d_we`, `sram_adr`/`sram_wdata`/`sram_wmask` come from the d_* inputs.
  - Otherwise: `sram_cs` = `fe_cs` | `lr_isram_cs_endp`, `sram_we` = 0, `sram_adr` from `fe_adr`, `sram_wdata` and `sram_wmask` = 0.
- Read returns:
  - `d_rvalid` <= `d_gnt` & !`d_we`.
  - `fe_rvalid` <= `sram_cs` & !`d_gnt`.
  - `d_rdata` = `sram_rdata`, pass-through, valid only with `d_rvalid`.
  - Writes produce no response; a write is complete at `d_gnt`.
- Simultaneous fetch and data request: data wins. The fetch request in that cycle is dropped; genpc holds pc via `lr_isram_cs`.
- Reset mid-burst: at the next edge the FSM returns to IDLE, `cnt`=0, and any pending rvalid is cleared. There is no endp pulse after reset.
- `d_adr` bits above `SRAM_AW+2` are ignored and alias within the SRAM; no error response.

Decomposition:
- Shared package `isram_pkg`:
  - FSM state encoding (IDLE=1'b0, DATA=1'b1).
  - `ISRAM_DW`=64, `ISRAM_MASKW`=8.
  - `MAX_DBURST` default.
- No sub-module. The burst counter and FSM are trivial enough to remain inline.

Test Plan:
1. Reset, then `fe_cs`=1, `fe_adr`=0x100 with no data traffic → `sram_cs`=1, `sram_adr`=0x100[SRAM_AW-1:0]; `fe_rvalid`=1 the next cycle; `lr_isram_cs`=0 throughout.
2. Single data read (`d_req`=1, `d_we`=0, `d_adr`=0x40) while `fe_cs`=1 → `d_gnt`=1 and `lr_isram_cs`=1 that cycle; next cycle `d_rvalid`=1, `d_rdata`=SRAM[0x40], `lr_isram_cs_endp`=1, `sram_adr` = fetch address.
3. Data write with `d_wmask`=8'h0F, `d_wdata`=64'hDEADBEEF_12345678 → `sram_we`=1 and the mask is passed through; a later data read of the same address returns bytes 0-3 updated and bytes 4-7 unchanged; no `d_rvalid` for the write.
4. `d_req` held high for 10 cycles with `MAX_DBURST`=4 → grant pattern 1111 0 1111 0 …; `lr_isram_cs_endp`=1 on cycles 5 and 10; `fe_rvalid` follows each endp cycle.
5. `cpurst` asserted on the 2nd cycle of a data burst → `d_gnt`=0 during reset, FSM=IDLE, `cnt`=0, no endp after deassertion, and the fetch port drives the SRAM.
